// File: rtl/gate_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_sequencer
// Purpose  : Exhaustive a/b vector BIST for quad 2-input gates. Each vector is
//            compared against a golden function and the mismatches are counted.
//            Optional GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
// Revision : 1.0  initial release
// ============================================================================
module gate_bist_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int OP     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     fail_count,
    output logic [2*WIDTH-1:0]   first_fail_vec
);

    localparam int IDX_W = 2 * WIDTH;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] c_IDX_MAX     = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [IDX_W-1:0]   r_idx,        w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
    logic [IDX_W:0]     r_fail_count, w_fail_nxt;
    logic [IDX_W-1:0]   r_first_fail, w_first_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_done,       w_done_nxt;
    logic [WIDTH-1:0]   w_golden;
    logic               w_mismatch;
    logic               w_last;

    // Golden gate function, evaluated on the vector currently driven out.
    always_comb begin
        w_golden = '0;
        case (OP)
            0:       w_golden = r_idx[IDX_W-1:WIDTH] & r_idx[WIDTH-1:0];
            1:       w_golden = r_idx[IDX_W-1:WIDTH] | r_idx[WIDTH-1:0];
            2:       w_golden = ~(r_idx[IDX_W-1:WIDTH] & r_idx[WIDTH-1:0]);
            default: w_golden = r_idx[IDX_W-1:WIDTH] ^ r_idx[WIDTH-1:0];
        endcase
    end

    assign w_mismatch = (y_in != w_golden);
    assign w_last     = (r_idx == c_IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fail_count <= w_fail_nxt;
            r_first_fail <= w_first_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_fail_nxt  = r_fail_count;
        w_first_nxt = r_first_fail;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_fail_nxt  = '0;
                    w_first_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = c_SETTLE_LOAD;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    w_fail_nxt = r_fail_count + 1'b1;
                    if (r_fail_count == '0) begin
                        w_first_nxt = r_idx;
                    end
                end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                if (w_last || w_mismatch) begin
`else
                if (w_last) begin
`endif
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_cnt_nxt   = c_SETTLE_LOAD;
                    w_state_nxt = S_SETTLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign a_out          = r_idx[IDX_W-1:WIDTH];
    assign b_out          = r_idx[WIDTH-1:0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done && (r_fail_count == '0);
    assign fail_count     = r_fail_count;
    assign first_fail_vec = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_sequencer
// Purpose  : Directed bench for gate_bist_sequencer with an ls7432/ls7486 model
//            and a stuck-at-0 fault option on y[0].
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_bist_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a, b, y, ax, bx, yx;
    logic       busy, done, pass, busy_x, done_x, pass_x;
    logic [8:0] fcnt, fcnt_x;
    logic [7:0] ffv, ffv_x;
    int         mode = 0;   // 0: good OR gate, 1: OR with y[0] stuck at 0, 2: XOR gate
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc;

    always #5 clk = ~clk;

    assign y  = (mode == 2) ? (a ^ b) : ((a | b) & ((mode == 1) ? 4'b1110 : 4'b1111));
    assign yx = ax ^ bx;

    gate_bist_sequencer #(.WIDTH(4), .SETTLE(2), .OP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a), .b_out(b), .y_in(y),
        .busy(busy), .done(done), .pass(pass), .fail_count(fcnt), .first_fail_vec(ffv)
    );

    gate_bist_sequencer #(.WIDTH(4), .SETTLE(2), .OP(3)) dut_x (
        .clk(clk), .rst(rst), .start(start), .a_out(ax), .b_out(bx), .y_in(yx),
        .busy(busy_x), .done(done_x), .pass(pass_x), .fail_count(fcnt_x), .first_fail_vec(ffv_x)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start into the next edge, then count edges until done. An optional
    // second start is pulsed when the vector index reaches poke_idx.
    task automatic run(input int poke_idx, output int cycles);
        bit poked = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            if (start) start = 1'b0;
            cycles++;
            if (done) break;
            if (!poked && poke_idx >= 0 && {a, b} == 8'(poke_idx)) begin
                poked = 1;
                @(negedge clk);
                start = 1'b1;
            end
        end
    endtask

    task automatic chk_result(input string tag, input int cycles, input int exp_cycles,
                              input int exp_fail, input int exp_first);
        chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        chk({tag, "_done"},   {31'd0, done}, 32'd1);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_pass"},   {31'd0, pass}, (exp_fail == 0) ? 32'd1 : 32'd0);
        chk({tag, "_fcnt"},   {23'd0, fcnt}, 32'(exp_fail));
        chk({tag, "_first"},  {24'd0, ffv},  32'(exp_first));
    endtask

    initial begin
        #12;
        chk("rst_ab",    {24'd0, a, b}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_pass",  {31'd0, pass}, 32'd0);
        chk("rst_fcnt",  {23'd0, fcnt}, 32'd0);
        chk("rst_first", {24'd0, ffv},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Good ls7432: 256 vectors * 3 cycles
        mode = 0;
        run(-1, cyc);
        chk_result("good", cyc, 768, 0, 0);
        chk("good_last_ab", {24'd0, a, b}, 32'h0000_00FF);
        chk("xor_pass",     {31'd0, pass_x}, 32'd1);
        chk("xor_fcnt",     {23'd0, fcnt_x}, 32'd0);

        // y[0] stuck at 0: fails whenever a[0]|b[0] -> 3/4 of 256 = 192
        mode = 1;
        run(-1, cyc);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk_result("stuck", cyc, 6, 1, 8'h01);
`else
        chk_result("stuck", cyc, 768, 192, 8'h01);
`endif

        // XOR gate vs OR golden: fails when a&b != 0 -> 256 - 3^4 = 175
        mode = 2;
        run(-1, cyc);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk_result("xor_vs_or", cyc, 54, 1, 8'h11);
`else
        chk_result("xor_vs_or", cyc, 768, 175, 8'h11);
`endif

        // Asynchronous reset mid-run at idx 0x40
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while ({a, b} != 8'h40 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reached_40", {24'd0, a, b}, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ab",   {24'd0, a, b}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(-1, cyc);
        chk_result("after_rst", cyc, 768, 0, 0);

        // Second start while busy at idx 0x10 must be ignored
        run(8'h10, cyc);
        chk_result("restart_ignored", cyc, 768, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
